// File: rtl/amber48_uart_pkg.sv
// Shared definitions for the amber48 UART transmit path and its arbiters.
package amber48_uart_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [0:0] {
      ARB   = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // Index width helper: $clog2 with a floor of one bit so that a
   // single-entry range still yields a legal vector.
   function automatic int clog2_min1(input int n);
      if (n <= 32'sd1) begin
         return 32'sd1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/amber48_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// scanning upward (with wrap) from the position after ptr_i.
module amber48_rr_pick
   import amber48_uart_pkg::*;
#(
   parameter int N  = 2,
   parameter int PW = 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [PW-1:0] idx_o,
   output logic          found_o
);

   // Choose the requester with the smallest circular distance from ptr_i+1.
   always_comb begin
      int best_d;
      int d;
      idx_o   = '0;
      found_o = 1'b0;
      best_d  = N;
      d       = 32'sd0;
      for (int i = 0; i < N; i++) begin
         d = (i + N - int'(ptr_i) - 32'sd1) % N;
         if (req_i[i] && (d < best_d)) begin
            best_d  = d;
            idx_o   = PW'(i);
            found_o = 1'b1;
         end else begin
            best_d = best_d;
         end
      end
   end

endmodule

// File: rtl/amber48_uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one amber48_uart_tx between
// NUM_REQ byte producers. A grant is held until the requester's last byte is
// accepted or until it has been idle for IDLE_TIMEOUT consecutive cycles.
module amber48_uart_tx_arb
   import amber48_uart_pkg::*;
#(
   parameter int NUM_REQ      = 2,
   parameter int IDLE_TIMEOUT = 1024
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ-1:0]             req_last_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic [UART_BYTE_W-1:0]         tx_data_o,
   output logic                           tx_valid_o,
   input  logic                           tx_ready_i,
   output logic [NUM_REQ-1:0]             grant_o,
   output logic                           busy_o,
   output logic                           timeout_o
);

   localparam int PW = clog2_min1(NUM_REQ);
   localparam int CW = clog2_min1(IDLE_TIMEOUT + 32'sd1);
   localparam logic TO_EN = (IDLE_TIMEOUT > 32'sd0);
   localparam logic [CW-1:0] TO_LAST = CW'((IDLE_TIMEOUT > 32'sd0) ? (IDLE_TIMEOUT - 32'sd1) : 32'sd0);
   localparam logic [CW-1:0] CNT_ONE = CW'(32'sd1);
   localparam logic [PW-1:0] PTR_RST = PW'(NUM_REQ - 32'sd1);

   arb_state_e       state_q, state_d;
   logic [PW-1:0]    grant_q, grant_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]    to_cnt_q, to_cnt_d;

   logic [PW-1:0]          pick_idx_s;
   logic                   pick_found_s;
   logic [UART_BYTE_W-1:0] sel_data_s;
   logic                   sel_valid_s;
   logic                   sel_last_s;
   logic                   xfer_s;
   logic                   expire_s;

   amber48_rr_pick #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx_s),
      .found_o (pick_found_s)
   );

   // Select the granted requester's byte, valid and last from the registered grant index.
   always_comb begin
      sel_data_s  = '0;
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q == PW'(i)) begin
            sel_data_s  = req_data_i[UART_BYTE_W*i +: UART_BYTE_W];
            sel_valid_s = req_valid_i[i];
            sel_last_s  = req_last_i[i];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   // Handshake and expiry qualifiers; the counter is only consulted when the timeout is enabled.
   always_comb begin
      xfer_s   = (state_q == GRANT) && sel_valid_s && tx_ready_i;
      expire_s = TO_EN && (state_q == GRANT) && !sel_valid_s && (to_cnt_q == TO_LAST);
   end

   // Drive the UART port and requester readies; everything is quiet outside GRANT.
   always_comb begin
      grant_o     = '0;
      req_ready_o = '0;
      tx_data_o   = '0;
      tx_valid_o  = 1'b0;
      busy_o      = 1'b0;
      timeout_o   = expire_s;
      if (state_q == GRANT) begin
         busy_o     = 1'b1;
         tx_data_o  = sel_data_s;
         tx_valid_o = sel_valid_s;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == PW'(i)) begin
               grant_o[i]     = 1'b1;
               req_ready_o[i] = tx_ready_i;
            end else begin
               grant_o[i]     = 1'b0;
               req_ready_o[i] = 1'b0;
            end
         end
      end else begin
         busy_o = 1'b0;
      end
   end

   // Next-state logic: arbitration, packet completion and inactivity timeout.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      to_cnt_d = to_cnt_q;
      case (state_q)
         ARB: begin
            if (pick_found_s) begin
               grant_d  = pick_idx_s;
               to_cnt_d = '0;
               state_d  = GRANT;
            end else begin
               state_d = ARB;
            end
         end
         GRANT: begin
            if (xfer_s) begin
               to_cnt_d = '0;
               if (sel_last_s) begin
                  ptr_d   = grant_q;
                  state_d = ARB;
               end else begin
                  state_d = GRANT;
               end
            end else if (sel_valid_s) begin
               // Waiting on a busy UART counts as activity.
               to_cnt_d = '0;
            end else if (expire_s) begin
               to_cnt_d = '0;
               ptr_d    = grant_q;
               state_d  = ARB;
            end else if (TO_EN) begin
               to_cnt_d = to_cnt_q + CNT_ONE;
            end else begin
               to_cnt_d = '0;
            end
         end
         default: begin
            state_d  = ARB;
            to_cnt_d = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset; pointer resets so requester 0 wins first.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ARB;
         grant_q  <= '0;
         ptr_q    <= PTR_RST;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         to_cnt_q <= to_cnt_d;
      end
   end

endmodule

// File: tb/tb_amber48_uart_tx_arb.sv
// Directed bench for amber48_uart_tx_arb. A behavioural UART stand-in accepts
// a byte and then stays busy for one frame (10 bits x 10 clocks).
module tb_amber48_uart_tx_arb;

   localparam int FRAME = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        rv [2];
   logic [7:0]  rd [2];
   logic        rl [2];
   logic [15:0] req_data;
   logic [1:0]  req_valid, req_last, req_ready, grant;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, busy, timeout;

   assign req_data  = {rd[1], rd[0]};
   assign req_valid = {rv[1], rv[0]};
   assign req_last  = {rl[1], rl[0]};

   amber48_uart_tx_arb #(.NUM_REQ(2), .IDLE_TIMEOUT(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .req_data_i(req_data), .req_valid_i(req_valid), .req_last_i(req_last),
      .req_ready_o(req_ready),
      .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
      .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
   );

   // Second instance: three requesters, timeout disabled.
   logic [23:0] d3;
   logic [2:0]  v3, l3, rdy3_o, g3;
   logic [7:0]  txd3;
   logic        txv3, txr3, busy3, to3;

   amber48_uart_tx_arb #(.NUM_REQ(3), .IDLE_TIMEOUT(0)) dut3 (
      .clk_i(clk), .rst_ni(rst_n),
      .req_data_i(d3), .req_valid_i(v3), .req_last_i(l3),
      .req_ready_o(rdy3_o),
      .tx_data_o(txd3), .tx_valid_o(txv3), .tx_ready_i(txr3),
      .grant_o(g3), .busy_o(busy3), .timeout_o(to3)
   );

   // UART stand-in and accepted-byte log {requester, byte}.
   int         busy_cnt = 0;
   logic       auto_mode = 1'b1;
   logic       man_ready = 1'b0;
   logic [8:0] log_q [$];

   assign tx_ready = auto_mode ? (busy_cnt == 0) : man_ready;

   always @(posedge clk) begin
      if (tx_valid && tx_ready) begin
         log_q.push_back({grant[1], tx_data});
         busy_cnt <= FRAME;
      end else if (busy_cnt > 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic pop_chk(input string tag, input logic [8:0] exp_v);
      logic [31:0] obs;
      if (log_q.size() > 0) obs = {23'd0, log_q.pop_front()};
      else obs = 32'hdead;
      check_eq(tag, obs, {23'd0, exp_v});
   endtask

   // Send an n-byte packet from requester r; called just after a posedge.
   task automatic send_pkt(input int r, input int n, input logic [7:0] base, input bit end_last);
      bit got;
      for (int i = 0; i < n; i++) begin
         rv[r] = 1'b1;
         rd[r] = base + 8'(i);
         rl[r] = (i == n - 1) && end_last;
         got = 1'b0;
         for (int c = 0; c < 1000 && !got; c++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1'b1;
         end
         if (!got) check_eq("send_wait", 32'd0, 32'd1);
         @(posedge clk); #1;
      end
      rv[r] = 1'b0;
      rl[r] = 1'b0;
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 300 && busy_cnt != 0; c++) @(posedge clk);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [2:0] exp3 [8];
   bit seen_to, seen_rdy, got;

   initial begin
      exp3 = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
      rv = '{1'b0, 1'b0}; rd = '{8'h00, 8'h00}; rl = '{1'b0, 1'b0};
      v3 = 3'b000; l3 = 3'b000; txr3 = 1'b0; d3 = {8'hC2, 8'hB1, 8'hA0};
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      v3 = 3'b111; l3 = 3'b111; txr3 = 1'b1;

      // Reset values, and 3-requester rotation with wrap 2 -> 0.
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 0) begin
            check_eq("rst_grant", grant, 2'b00);
            check_eq("rst_busy", busy, 1'b0);
            check_eq("rst_timeout", timeout, 1'b0);
            check_eq("rst_tx_valid", tx_valid, 1'b0);
            check_eq("rst_req_ready", req_ready, 2'b00);
            check_eq("rst_tx_data", tx_data, 8'h00);
         end
         check_eq($sformatf("rot3_grant_%0d", k), g3, exp3[k]);
         if (k == 3) check_eq("rot3_data", txd3, 8'hB1);
      end
      @(posedge clk); #1;
      v3 = 3'b000;

      // Timeout disabled: an idle grant is kept.
      v3 = 3'b001; l3 = 3'b000; txr3 = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("nto_grant", g3, 3'b001);
      @(posedge clk); #1;
      v3 = 3'b000;
      seen_to = 1'b0;
      repeat (40) begin @(negedge clk); if (to3) seen_to = 1'b1; end
      check_eq("nto_no_pulse", seen_to, 1'b0);
      check_eq("nto_busy", busy3, 1'b1);
      @(posedge clk); #1;
      v3 = 3'b001; l3 = 3'b001; txr3 = 1'b1;
      @(posedge clk); #1;
      v3 = 3'b000; l3 = 3'b000; txr3 = 1'b0;
      @(negedge clk);
      check_eq("nto_release", busy3, 1'b0);

      // Test 1: single 2-byte packet from requester 0.
      wait_idle();
      rv[0] = 1'b1; rd[0] = 8'h41; rl[0] = 1'b0;
      @(negedge clk);
      check_eq("t1_grant_n", grant, 2'b00);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("t1_grant_n1", grant, 2'b01);
      check_eq("t1_busy_n1", busy, 1'b1);
      check_eq("t1_tx_valid", tx_valid, 1'b1);
      check_eq("t1_tx_data", tx_data, 8'h41);
      check_eq("t1_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      rd[0] = 8'h42; rl[0] = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if (req_ready[0]) got = 1'b1;
      end
      check_eq("t1_second_ready", got, 1'b1);
      @(posedge clk); #1;
      rv[0] = 1'b0; rl[0] = 1'b0;
      @(negedge clk);
      check_eq("t1_grant_m1", grant, 2'b00);
      check_eq("t1_busy_m1", busy, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("t1_grant_m2", grant, 2'b00);
      check_eq("t1_log_n", log_q.size(), 32'd2);
      pop_chk("t1_b0", {1'b0, 8'h41});
      pop_chk("t1_b1", {1'b0, 8'h42});

      // Test 2: simultaneous 3-byte packets, no interleave.
      wait_idle();
      do_reset();
      fork
         send_pkt(0, 3, 8'h10, 1'b1);
         send_pkt(1, 3, 8'h20, 1'b1);
      join
      pop_chk("t2_b0", {1'b0, 8'h10});
      pop_chk("t2_b1", {1'b0, 8'h11});
      pop_chk("t2_b2", {1'b0, 8'h12});
      pop_chk("t2_b3", {1'b1, 8'h20});
      pop_chk("t2_b4", {1'b1, 8'h21});
      pop_chk("t2_b5", {1'b1, 8'h22});

      // Test 3: requester 1 re-requests, requester 0 is not starved.
      wait_idle();
      fork
         begin
            send_pkt(1, 1, 8'hA0, 1'b1);
            send_pkt(1, 1, 8'hA1, 1'b1);
            send_pkt(1, 1, 8'hA2, 1'b1);
         end
         begin
            @(posedge clk); #1;
            send_pkt(0, 1, 8'hB0, 1'b1);
         end
      join
      pop_chk("t3_s0", {1'b1, 8'hA0});
      pop_chk("t3_s1", {1'b0, 8'hB0});
      pop_chk("t3_s2", {1'b1, 8'hA1});
      pop_chk("t3_s3", {1'b1, 8'hA2});

      // Test 4: stalled requester 0 is revoked after 16 idle cycles.
      wait_idle();
      rv[1] = 1'b1; rd[1] = 8'h66; rl[1] = 1'b1;
      send_pkt(0, 1, 8'h55, 1'b0);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 15) check_eq("t4_no_early", timeout, 1'b0);
         if (k == 16) begin
            check_eq("t4_pulse", timeout, 1'b1);
            check_eq("t4_busy_at_pulse", busy, 1'b1);
         end
         if (k == 17) begin
            check_eq("t4_arb_busy", busy, 1'b0);
            check_eq("t4_pulse_width", timeout, 1'b0);
         end
         if (k == 18) check_eq("t4_next_grant", grant, 2'b10);
      end
      send_pkt(1, 1, 8'h66, 1'b1);
      pop_chk("t4_b0", {1'b0, 8'h55});
      pop_chk("t4_b1", {1'b1, 8'h66});

      // Test 5: reset mid-packet.
      wait_idle();
      auto_mode = 1'b0; man_ready = 1'b0;
      rv[0] = 1'b1; rd[0] = 8'h31; rl[0] = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("t5_granted", grant, 2'b01);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rv[1] = 1'b1; rd[1] = 8'h32; rl[1] = 1'b1;
      @(negedge clk);
      check_eq("t5_grant", grant, 2'b00);
      check_eq("t5_busy", busy, 1'b0);
      check_eq("t5_timeout", timeout, 1'b0);
      check_eq("t5_tx_valid", tx_valid, 1'b0);
      check_eq("t5_req_ready", req_ready, 2'b00);
      check_eq("t5_tx_data", tx_data, 8'h00);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("t5_regrant", grant, 2'b01);
      @(posedge clk); #1;
      rv[1] = 1'b0; rl[1] = 1'b0; rl[0] = 1'b1; man_ready = 1'b1;
      @(negedge clk);
      check_eq("t5_flush_ready", req_ready, 2'b01);
      @(posedge clk); #1;
      rv[0] = 1'b0; rl[0] = 1'b0; man_ready = 1'b0;
      pop_chk("t5_b0", {1'b0, 8'h31});

      // Test 6: a long UART-busy wait is not a stall.
      rv[0] = 1'b1; rd[0] = 8'h77; rl[0] = 1'b1;
      seen_to = 1'b0; seen_rdy = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (timeout) seen_to = 1'b1;
         if (req_ready[0]) seen_rdy = 1'b1;
      end
      check_eq("t6_no_timeout", seen_to, 1'b0);
      check_eq("t6_no_ready", seen_rdy, 1'b0);
      check_eq("t6_still_busy", busy, 1'b1);
      @(posedge clk); #1;
      man_ready = 1'b1;
      @(negedge clk);
      check_eq("t6_ready", req_ready, 2'b01);
      check_eq("t6_data", tx_data, 8'h77);
      @(posedge clk); #1;
      rv[0] = 1'b0; rl[0] = 1'b0; man_ready = 1'b0;
      @(negedge clk);
      check_eq("t6_released", busy, 1'b0);
      pop_chk("t6_b0", {1'b0, 8'h77});
      auto_mode = 1'b1;
      check_eq("log_empty", log_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
